stage_mem1: RTL
===============

// Module: stage_mem1
// PURPOSE
// - First memory stage; sits between EX and stage_mem2.
// - Issues load/store requests to the LSU with a req/gnt handshake and aligns store data/byte enables.
// - Detects misaligned accesses, tracks outstanding LSU transactions, and holds the MEM1/MEM2 pipeline registers.
// PARAMETERS
// - MAX_OUTSTANDING  1  max granted LSU requests not yet answered by lsu_req_done_i (1..3)
// PORTS
// - clk_i            in   1   clock
// - rstn_i           in   1   asynchronous active-low reset
// - alu_result_i     in   32  effective address / ALU result from EX
// - mem_oper_i       in   mem_oper_t  MEM_NOP, MEM_LB/LBU/LH/LHU/LW, MEM_SB/SH/SW
// - rs2_data_i       in   32  store data
// - csr_wdata_i      in   32  passthrough
// - csr_waddr_i      in   12  passthrough
// - csr_we_i         in   1   passthrough
// - trap_i           in   exc_t  incoming trap (NO_TRAP if none)
// - write_rd_i       in   1   passthrough
// - rd_addr_i        in   5   passthrough
// - stall_i          in   1   stall from stage_mem2
// - flush_i          in   1   kill instruction in MEM1
// - lsu_req_o        out  1   request valid
// - lsu_we_o         out  1   1=store
// - lsu_addr_o       out  32  word-aligned address ({alu_result_i[31:2],2'b00})
// - lsu_be_o         out  4   byte enables
// - lsu_wdata_o      out  32  lane-replicated store data
// - lsu_gnt_i        in   1   request accepted this cycle
// - lsu_req_done_i   in   1   one outstanding transaction completed
// - alu_result_o, mem_oper_o, csr_wdata_o, csr_waddr_o, csr_we_o, trap_o, write_rd_o, rd_addr_o
//     out  (as inputs)  MEM1/MEM2 pipeline registers
// - stall_o          out  1   stall to upstream stages
// BEHAVIOUR
// - Reset (async, rstn_i low) and flush_i (sync):
//     - mem_oper_o=MEM_NOP; write_rd_o=0; csr_we_o=0; trap_o=NO_TRAP.
//     - All other pipeline outputs 0; FSM=IDLE.
//     - Outstanding counter cleared on reset only; flush_i leaves it untouched.
// - Access needed: mem_oper_i!=MEM_NOP, trap_i==NO_TRAP, and no misaligned trap.
// - Byte enables and store data:
//     - SB/LB/LBU: be=4'b0001<<a[1:0]; wdata={4{rs2[7:0]}}.
//     - SH/LH/LHU: be=4'b0011<<{a[1],1'b0}; wdata={2{rs2[15:0]}}.
//     - SW/LW: be=4'b1111; wdata=rs2.
// - lsu_req_o = needed && state!=GRANTED && cnt<MAX_OUTSTANDING; combinational, no extra latency.
// - Counter: +1 on req&&gnt; -1 on lsu_req_done_i; both in one cycle = no change.
//     - Never exceeds MAX_OUTSTANDING; done with cnt==0 is ignored.
// - FSM:
//     - IDLE: req&&gnt&&stall_i -> GRANTED; req&&!gnt stays IDLE and holds req, addr, be, wdata stable.
//     - GRANTED: on !stall_i -> IDLE. Never re-requests the same instruction.
// - stall_o = stall_i | (needed && !(state==GRANTED || (lsu_req_o && lsu_gnt_i))).
// - Pipeline registers:
//     - stall_i=1: hold all values.
//     - stall_o=1 and stall_i=0: insert bubble (reset values).
//     - Otherwise: load inputs; trap_o=trap_i, or the misalign trap.
// - Flush on a granted request: FSM -> IDLE, bubble inserted, counter still awaits its done.
// CONFIGURATION
// - YARC_MISALIGN_TRAP_EN defined:
//     - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, raise a trap and issue no request.
//     - Loads: trap_o=LOAD_ADDR_MISALIGNED. Stores: trap_o=STORE_ADDR_MISALIGNED.
// - Undefined: no trap; a[0] ignored for halfword ops and a[1:0] ignored for word ops (access the aligned lanes).
// TESTING
// - SB a=0x1003 rs2=0x000000A5, gnt same cycle -> req=1 we=1 addr=0x1000 be=4'b1000 wdata=0xA5A5A5A5; no stall.
// - LW a=0x2000, gnt after 3 cycles -> stall_o=1 for 3 cycles, 3 bubbles out, exactly one granted req.
// - LH a=0x2002, gnt while stall_i=1 for 2 cycles -> GRANTED, req=0 during hold, outputs held, one grant only.
// - MAX_OUTSTANDING=1: LW then LW with done delayed 2 cycles -> 2nd req low, stall_o=1 until done.
// - LW a=0x3002 -> with macro: trap_o=LOAD_ADDR_MISALIGNED, req=0; without: req addr=0x3000 be=4'b1111.
// - Reset asserted while IDLE is waiting for gnt -> all outputs at reset values immediately; cnt=0; req=0.

Source files
------------

// File: rtl/stage_mem1_if.sv
// Shared MEM1 types plus the LSU request/grant bus between stage_mem1 (master) and the LSU (slave).
// The typedefs sit in compilation-unit scope so the stage, the LSU and benches share one definition.

typedef enum logic [3:0] {
  MEM_NOP = 4'd0,
  MEM_LB,
  MEM_LBU,
  MEM_LH,
  MEM_LHU,
  MEM_LW,
  MEM_SB,
  MEM_SH,
  MEM_SW
} mem_oper_t;

typedef enum logic [3:0] {
  NO_TRAP = 4'd0,
  INSTR_ADDR_MISALIGNED,
  ILLEGAL_INSTR,
  LOAD_ADDR_MISALIGNED,
  STORE_ADDR_MISALIGNED,
  ECALL_M
} exc_t;

interface stage_mem1_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        req_done;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, req_done
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, req_done
  );
endinterface

// File: rtl/stage_mem1.sv
// First memory stage: issues LSU requests, aligns store data, tracks outstanding accesses, holds MEM1/MEM2 regs.
// Optional feature: define YARC_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of aligning them.

module stage_mem1 #(
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [31:0]         alu_result_i,
  input  mem_oper_t           mem_oper_i,
  input  logic [31:0]         rs2_data_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [11:0]         csr_waddr_i,
  input  logic                csr_we_i,
  input  exc_t                trap_i,
  input  logic                write_rd_i,
  input  logic [4:0]          rd_addr_i,
  input  logic                stall_i,
  input  logic                flush_i,
  stage_mem1_if.master        lsu,
  output logic [31:0]         alu_result_o,
  output mem_oper_t           mem_oper_o,
  output logic [31:0]         csr_wdata_o,
  output logic [11:0]         csr_waddr_o,
  output logic                csr_we_o,
  output exc_t                trap_o,
  output logic                write_rd_o,
  output logic [4:0]          rd_addr_o,
  output logic                stall_o
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  typedef enum logic {
    S_IDLE,
    S_GRANTED
  } state_t;

  typedef struct packed {
    logic [31:0] alu_result;
    mem_oper_t   mem_oper;
    logic [31:0] csr_wdata;
    logic [11:0] csr_waddr;
    logic        csr_we;
    exc_t        trap;
    logic        write_rd;
    logic [4:0]  rd_addr;
  } pipe_t;

  localparam pipe_t PIPE_BUBBLE = '{
    alu_result: 32'd0,
    mem_oper:   MEM_NOP,
    csr_wdata:  32'd0,
    csr_waddr:  12'd0,
    csr_we:     1'b0,
    trap:       NO_TRAP,
    write_rd:   1'b0,
    rd_addr:    5'd0
  };

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  pipe_t       pipe_q, pipe_d;

  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misalign;
  exc_t        misalign_trap;
  logic        needed;
  logic        req;
  logic        grant;
  logic        done_valid;
  logic [3:0]  be;
  logic [31:0] wdata;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_oper_i)
      MEM_LB, MEM_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      MEM_LH, MEM_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MEM_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      MEM_SB:          begin is_store = 1'b1; is_byte = 1'b1; end
      MEM_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      MEM_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

`ifdef YARC_MISALIGN_TRAP_EN
  assign misalign = (is_half && alu_result_i[0]) || (is_word && (alu_result_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign misalign_trap = is_store ? STORE_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
  assign needed        = (is_load || is_store) && (trap_i == NO_TRAP) && !misalign;

  // Lane placement; without the trap option the low address bits just select aligned lanes.
  always_comb begin
    be    = 4'b0000;
    wdata = rs2_data_i;
    if (is_byte) begin
      be    = 4'b0001 << alu_result_i[1:0];
      wdata = {4{rs2_data_i[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << {alu_result_i[1], 1'b0};
      wdata = {2{rs2_data_i[15:0]}};
    end else if (is_word) begin
      be    = 4'b1111;
      wdata = rs2_data_i;
    end
  end

  // Gating with rstn_i keeps the request low for the whole time reset is held.
  assign req        = rstn_i && needed && (state_q != S_GRANTED) && (cnt_q < MAX_CNT);
  assign grant      = req && lsu.gnt;
  assign done_valid = lsu.req_done && (cnt_q != 2'd0);

  assign lsu.req   = req;
  assign lsu.we    = is_store;
  assign lsu.addr  = {alu_result_i[31:2], 2'b00};
  assign lsu.be    = be;
  assign lsu.wdata = wdata;

  assign stall_o = stall_i || (needed && !((state_q == S_GRANTED) || grant));

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !done_valid) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!grant && done_valid) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (grant && stall_i) state_d = S_GRANTED;
        S_GRANTED: if (!stall_i)         state_d = S_IDLE;
        default:                         state_d = S_IDLE;
      endcase
    end
  end

  // A flushed request still owns its counter slot until the LSU reports done.
  always_comb begin
    pipe_d = pipe_q;
    if (flush_i) begin
      pipe_d = PIPE_BUBBLE;
    end else if (stall_i) begin
      pipe_d = pipe_q;
    end else if (stall_o) begin
      pipe_d = PIPE_BUBBLE;
    end else begin
      pipe_d.alu_result = alu_result_i;
      pipe_d.mem_oper   = mem_oper_i;
      pipe_d.csr_wdata  = csr_wdata_i;
      pipe_d.csr_waddr  = csr_waddr_i;
      pipe_d.csr_we     = csr_we_i;
      pipe_d.trap       = (trap_i == NO_TRAP && misalign) ? misalign_trap : trap_i;
      pipe_d.write_rd   = write_rd_i;
      pipe_d.rd_addr    = rd_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      pipe_q  <= PIPE_BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
    end
  end

  assign alu_result_o = pipe_q.alu_result;
  assign mem_oper_o   = pipe_q.mem_oper;
  assign csr_wdata_o  = pipe_q.csr_wdata;
  assign csr_waddr_o  = pipe_q.csr_waddr;
  assign csr_we_o     = pipe_q.csr_we;
  assign trap_o       = pipe_q.trap;
  assign write_rd_o   = pipe_q.write_rd;
  assign rd_addr_o    = pipe_q.rd_addr;

endmodule
